axis_pkt_arbiter: RTL

AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

---
 rtl/axis_pkg.sv | 41 ++++
 rtl/axis_out_reg.sv | 56 +++++
 rtl/axis_pkt_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream packet arbiter family.
//   arb_state_t : two-state arbiter FSM encoding (IDLE / LOCK)
//   RR_MAX      : largest source count supported by rr_pick
//   rr_pick     : round-robin winner search starting one past the previous
//                 grant, wrapping modulo the live source count
// -----------------------------------------------------------------------------
package axis_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    localparam int RR_MAX = 8;

    // Returns the first requesting index found at (last+1), (last+2), ...
    // modulo nsrc. When nothing requests, the previous grant is returned;
    // callers only use the result when at least one request is present.
    function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] req,
                                           input logic [2:0]        last,
                                           input int                nsrc);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            if (k <= nsrc) begin
                idx = (int'(last) + k) % nsrc;
                if (!found && req[idx]) begin
                    win   = 3'(idx);
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
// Single-entry registered AXI-Stream output stage. A beat presented with
// i_load is captured and held until the consumer takes it.
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   i_load       : capture i_data/i_last this cycle (only when o_space=1)
//   i_data       : beat data (DW bits)
//   i_last       : beat end-of-packet flag
//   i_ready      : downstream ready
//   o_space      : register can take a beat this cycle (empty or draining)
//   o_valid      : registered valid
//   o_data       : registered data
//   o_last       : registered last
// -----------------------------------------------------------------------------
module axis_out_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    input  logic          i_ready,
    output logic          o_space,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_last
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            // Beat consumed with nothing behind it: drain. Data/last keep
            // their old value, which is harmless while valid is low.
            r_valid <= 1'b0;
        end
    end

    assign o_space = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/axis_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// axis_pkt_arbiter
// Packet-level round-robin arbiter merging NSRC AXI-Stream sources into one
// registered output. A source is locked from its first beat until its last
// beat is accepted; arbitration costs one idle cycle between packets.
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   s_axis_data   : packed source data, source i at [i*DW +: DW]
//   s_axis_valid  : per-source valid
//   s_axis_last   : per-source end-of-packet
//   s_axis_ready  : per-source ready, one-hot or zero
//   m_axis_*      : registered merged output stream
//   grant_idx     : currently / most recently locked source
//   busy          : a packet is locked
//   pkt_len       : beat count of the last completed packet (saturating)
//   pkt_done      : one-cycle pulse after a packet's last beat is accepted
// -----------------------------------------------------------------------------
module axis_pkt_arbiter
    import axis_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NSRC = 4,
    parameter int LENW = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NSRC*DW-1:0]       s_axis_data,
    input  logic [NSRC-1:0]          s_axis_valid,
    input  logic [NSRC-1:0]          s_axis_last,
    output logic [NSRC-1:0]          s_axis_ready,
    output logic [DW-1:0]            m_axis_data,
    output logic                     m_axis_valid,
    output logic                     m_axis_last,
    input  logic                     m_axis_ready,
    output logic [$clog2(NSRC)-1:0]  grant_idx,
    output logic                     busy,
    output logic [LENW-1:0]          pkt_len,
    output logic                     pkt_done
);

    localparam int GW = $clog2(NSRC);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_last_grant;
    logic [GW-1:0]   w_pick;
    logic [LENW-1:0] r_cnt;
    logic [LENW-1:0] r_pkt_len;
    logic            r_pkt_done;
    logic            w_space;
    logic            w_accept;
    logic            w_sel_last;
    logic [DW-1:0]   w_sel_data;
    logic [NSRC-1:0] w_ready;
    logic            w_start;
    logic            w_end;

    function automatic logic [LENW-1:0] sat_inc(input logic [LENW-1:0] v);
        return (&v) ? v : v + LENW'(1);
    endfunction

    assign w_pick     = GW'(rr_pick(8'(s_axis_valid), 3'(r_last_grant), NSRC));
    assign w_sel_last = s_axis_last[r_grant];
    assign w_sel_data = s_axis_data[int'(r_grant)*DW +: DW];
    assign w_accept   = |(w_ready & s_axis_valid);

    // Only the locked source ever sees ready, and only when the output
    // register can take the beat.
    always_comb begin
        w_ready = '0;
        if (r_state == ST_LOCK && w_space) begin
            w_ready[r_grant] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|s_axis_valid) begin
                    w_state_nxt = ST_LOCK;
                    w_start     = 1'b1;
                end
            end
            ST_LOCK: begin
                // A stalled source (valid low) keeps the lock indefinitely.
                if (w_accept && w_sel_last) begin
                    w_state_nxt = ST_IDLE;
                    w_end       = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NSRC - 1);
            r_cnt        <= '0;
            r_pkt_len    <= '0;
            r_pkt_done   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pkt_done <= w_end;
            if (w_start) begin
                r_grant <= w_pick;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_cnt <= sat_inc(r_cnt);
            end
            if (w_end) begin
                r_last_grant <= r_grant;
                // The closing beat is counted here since r_cnt has not seen it.
                r_pkt_len    <= sat_inc(r_cnt);
            end
        end
    end

    axis_out_reg #(
        .DW(DW)
    ) u_out_reg (
        .clk     (clk),
        .resetn  (resetn),
        .i_load  (w_accept),
        .i_data  (w_sel_data),
        .i_last  (w_sel_last),
        .i_ready (m_axis_ready),
        .o_space (w_space),
        .o_valid (m_axis_valid),
        .o_data  (m_axis_data),
        .o_last  (m_axis_last)
    );

    assign s_axis_ready = w_ready;
    assign grant_idx    = r_grant;
    assign busy         = (r_state == ST_LOCK);
    assign pkt_len      = r_pkt_len;
    assign pkt_done     = r_pkt_done;

endmodule
